// File: rtl/sram_1rw_arbiter.sv
// Two-requester round-robin front end for a single-port 1RW SRAM; one transaction in flight.
// Writes occupy 2 cycles accept-to-accept; reads return rdata with a one-cycle rvalid pulse after READ and CAPTURE.
module sram_1rw_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rvalid,

    output logic [DATA_WIDTH-1:0] rdata,

    output logic                  sram_csb,
    output logic                  sram_web,
    output logic                  sram_oeb,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  sram_dout_en,
    input  logic [DATA_WIDTH-1:0] sram_din
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WRITE   = 2'd1;
    localparam logic [1:0] READ    = 2'd2;
    localparam logic [1:0] CAPTURE = 2'd3;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    logic [1:0]            state_q,    state_d;
    logic                  last_q,     last_d;
    logic                  owner_q,    owner_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] dout_q,     dout_d;
    logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;

    logic                  is_idle;
    logic                  grant_a;
    logic                  grant_b;
    logic                  accept;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // On a tie, the requester that was not granted last wins.
    assign grant_a = a_valid && (!b_valid || (last_q == GNT_B));
    assign grant_b = b_valid && !grant_a;
    assign is_idle = (state_q == IDLE);

    assign a_ready = is_idle && grant_a;
    assign b_ready = is_idle && grant_b;
    assign accept  = a_ready || b_ready;

    assign sel_we    = grant_a ? a_we    : b_we;
    assign sel_addr  = grant_a ? a_addr  : b_addr;
    assign sel_wdata = grant_a ? a_wdata : b_wdata;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        rdata_d    = rdata_q;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_d  = grant_a ? GNT_A : GNT_B;
                    owner_d = grant_a ? GNT_A : GNT_B;
                    addr_d  = sel_addr;
                    if (sel_we) begin
                        dout_d  = sel_wdata;
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // The SRAM has had a full cycle of oeb low, so the bus is settled here.
                rdata_d    = sram_din;
                a_rvalid_d = (owner_q == GNT_A);
                b_rvalid_d = (owner_q == GNT_B);
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= GNT_B;
            owner_q    <= GNT_A;
            addr_q     <= '0;
            dout_q     <= '0;
            rdata_q    <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            rdata_q    <= rdata_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    // Strobes decode directly from the state flop so reset releases the SRAM immediately.
    assign sram_csb     = is_idle;
    assign sram_web     = (state_q != WRITE);
    assign sram_oeb     = !((state_q == READ) || (state_q == CAPTURE));
    assign sram_dout_en = (state_q == WRITE);
    assign sram_addr    = addr_q;
    assign sram_dout    = dout_q;

    assign rdata    = rdata_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;

endmodule
